// File: rtl/serdes_lvds_pkg.sv
// Shared LVDS lane definitions: lane/bit geometry, TX FSM encoding, lane map.
// Latency: n/a (package only).
// Backpressure: n/a. lane_scramble is the bit-exact inverse of the receive-side map.
package serdes_lvds_pkg;

    localparam int LANES = 8;
    localparam int BITS  = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_TRAIN = 1'b1
    } state_t;

    // Bit-interleave LANES bytes into one OSERDES word. Lane k bit b lands at
    // o[BITS*(BITS-1-b) + (LANES-1-k)]: the top byte carries bit 0 of every
    // lane, and within a byte lane 0 is the MSB. Lane k is inverted when
    // inv[k] is set.
    function automatic logic [LANES*BITS-1:0] lane_scramble(
        input logic [LANES*BITS-1:0] lanes,
        input logic [LANES-1:0]      inv
    );
        logic [LANES*BITS-1:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < BITS; b++) begin
                w[BITS*(BITS-1-b) + (LANES-1-k)] = lanes[BITS*k + b] ^ inv[k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serdes_tx_fifo.sv
// Synchronous FIFO holding lane beats ahead of the scrambler.
// Latency: a write is visible (empty drops) the cycle after it is accepted; rd_data is the head, read combinationally.
// Backpressure: full/empty are registered; writes when full and reads when empty are ignored.
// Ports: clk, rst (sync, active high), wr_en/wr_data, rd_en/rd_data, full, empty, count.
module serdes_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            // Flags are updated from the pre-increment count so they stay registered.
            case ({do_wr, do_rd})
                2'b10: begin
                    count <= count + 1'b1;
                    empty <= 1'b0;
                    full  <= (count == CNT_LAST);
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == CNT_ONE);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/serdes_scramble_tx.sv
// LVDS transmit lane packer: buffers 8-lane beats and emits one bit-interleaved, polarity-corrected OSERDES word per cycle.
// Latency: beat pushed at edge N appears on o_lvds after edge N+2 (FIFO -> head register -> output register).
// Backpressure: o_ready = !fifo_full (low in reset); empty FIFO sends IDLE_WORD and counts an underflow.
// Ports: clk, rst (sync, active high); i_data/i_valid/o_ready input beats; i_train starts a bitslip
//        training burst (o_training, o_train_done); i_clear zeroes o_underflow_count; o_lvds is the registered word.
module serdes_scramble_tx
    import serdes_lvds_pkg::*;
#(
    parameter logic [7:0] INVERT_MAP    = 8'h00,
    parameter logic [7:0] IDLE_WORD     = 8'h00,
    parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
    parameter int         TRAIN_CYCLES  = 64,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_train,
    input  logic        i_clear,
    output logic [63:0] o_lvds,
    output logic        o_training,
    output logic        o_train_done,
    output logic [15:0] o_underflow_count
);

    localparam int TCW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
    localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_CYCLES - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LANES*BITS-1:0] IDLE_SCR =
        lane_scramble({LANES{IDLE_WORD}}, INVERT_MAP);

    state_t                state;
    state_t                state_nxt;
    logic [TCW-1:0]        train_cnt;
    logic                  train_last;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [LANES*BITS-1:0] fifo_head;
    logic [LANES*BITS-1:0] head_dat;
    logic                  head_vld;
    logic [LANES*BITS-1:0] lanes_sel;
    logic                  underflow;

    assign o_ready = !rst && !fifo_full;
    assign push    = i_valid && o_ready;

    serdes_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LANES*BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (i_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        train_last = 1'b0;
        case (state)
            ST_RUN: begin
                pop = !fifo_empty;
                if (i_train) state_nxt = ST_TRAIN;
            end
            ST_TRAIN: begin
                train_last = (train_cnt == TRAIN_LAST);
                if (train_last) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state != ST_TRAIN || train_last) train_cnt <= '0;
        else                                        train_cnt <= train_cnt + 1'b1;
    end

    // Head register. It freezes during TRAIN so a beat popped in the cycle
    // i_train arrives is held and sent once training finishes, not dropped.
    always_ff @(posedge clk) begin
        if (rst)                  head_vld <= 1'b0;
        else if (state == ST_RUN) head_vld <= pop;
    end

    always_ff @(posedge clk) begin
        if (pop) head_dat <= fifo_head;
    end

    assign underflow = (state == ST_RUN) && !head_vld;

    always_comb begin
        lanes_sel = {LANES{IDLE_WORD}};
        if (state == ST_TRAIN) lanes_sel = {LANES{TRAIN_PATTERN}};
        else if (head_vld)     lanes_sel = head_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_lvds            <= IDLE_SCR;
            o_training        <= 1'b0;
            o_train_done      <= 1'b0;
            o_underflow_count <= '0;
        end else begin
            o_lvds       <= lane_scramble(lanes_sel, INVERT_MAP);
            o_training   <= (state == ST_TRAIN);
            // o_training still reflects the last TRAIN cycle here, so this
            // fires exactly on the first word after the burst.
            o_train_done <= o_training && (state == ST_RUN);
            if (i_clear)
                o_underflow_count <= '0;
            else if (underflow && o_underflow_count != 16'hFFFF)
                o_underflow_count <= o_underflow_count + 16'd1;
        end
    end

    a_full_flag: assert property (@(posedge clk) disable iff (rst)
        fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
    a_empty_flag: assert property (@(posedge clk) disable iff (rst)
        fifo_empty == (fifo_count == '0));

endmodule

// File: tb/tb_serdes_scramble_tx.sv
// Directed bench: two instances (defaults; INVERT_MAP=01 with TRAIN_CYCLES=3) share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected words come from hand-computed constants and an independent lane-map model.
module tb_serdes_scramble_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_data;
    logic        i_valid;
    logic        i_train;
    logic        i_clear;

    logic        rdy0, trn0, done0;
    logic        rdy1, trn1, done1;
    logic [63:0] lvds0, lvds1;
    logic [15:0] uf0, uf1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serdes_scramble_tx dut0 (
        .clk               (clk),
        .rst               (rst),
        .i_data            (i_data),
        .i_valid           (i_valid),
        .o_ready           (rdy0),
        .i_train           (i_train),
        .i_clear           (i_clear),
        .o_lvds            (lvds0),
        .o_training        (trn0),
        .o_train_done      (done0),
        .o_underflow_count (uf0)
    );

    serdes_scramble_tx #(
        .INVERT_MAP   (8'h01),
        .TRAIN_CYCLES (3)
    ) dut1 (
        .clk               (clk),
        .rst               (rst),
        .i_data            (i_data),
        .i_valid           (i_valid),
        .o_ready           (rdy1),
        .i_train           (i_train),
        .i_clear           (i_clear),
        .o_lvds            (lvds1),
        .o_training        (trn1),
        .o_train_done      (done1),
        .o_underflow_count (uf1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output bit i carries lane (7 - i%8), bit (7 - i/8).
    function automatic logic [63:0] model_scr(input logic [63:0] lanes, input logic [7:0] inv);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            int b;
            int k;
            b = 7 - i / 8;
            k = 7 - i % 8;
            w[i] = lanes[8*k + b] ^ inv[k];
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] b2b [3];
        logic [63:0] bp  [6];
        bit          took;
        int          acc;
        int          w;

        b2b[0] = 64'h0123456789ABCDEF;
        b2b[1] = 64'hFFFF0000A5A5C3C3;
        b2b[2] = 64'h8000000000000001;
        bp[0]  = 64'h1111111111111111;
        bp[1]  = 64'h2222222222222222;
        bp[2]  = 64'h0F0F0F0F0F0F0F0F;
        bp[3]  = 64'h8040201008040201;
        bp[4]  = 64'h5555555555555555;
        bp[5]  = 64'h6666666666666666;

        rst = 1'b1; i_valid = 1'b0; i_train = 1'b0; i_clear = 1'b0; i_data = '0;
        repeat (3) tick();
        chk("rst_ready",    64'(rdy0), 64'd0);
        chk("rst_lvds0",    lvds0, 64'h0);
        chk("rst_lvds1",    lvds1, 64'h8080808080808080);
        chk("rst_training", 64'(trn0), 64'd0);
        chk("rst_done",     64'(done0), 64'd0);
        chk("rst_uf",       64'(uf0), 64'd0);

        // Release: idle words, counter runs one per cycle.
        rst = 1'b0;
        tick();
        chk("rel_ready", 64'(rdy0), 64'd1);
        chk("rel_uf1",   64'(uf0), 64'd1);
        chk("rel_lvds1", lvds1, 64'h8080808080808080);
        tick();
        chk("rel_uf2",   64'(uf0), 64'd2);

        // Single beat latency: pushed at edge N, visible after N+2.
        i_data = 64'h0807060504030201; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("lat_n0",   lvds0, 64'h0);
        tick();
        chk("lat_n1",   lvds0, 64'h0);
        chk("lat_uf",   64'(uf0), 64'd4);
        tick();
        chk("lat_n2_d0", lvds0, 64'hAA661E0100000000);
        chk("lat_n2_d1", lvds1, 64'h2AE69E8180808080);
        chk("lat_uf_hold", 64'(uf0), 64'd4);

        // Back-to-back beats come out on consecutive cycles.
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                i_valid = 1'b1;
                i_data  = b2b[c];
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (c >= 2) begin
                chk("b2b_d0", lvds0, model_scr(b2b[c-2], 8'h00));
                chk("b2b_d1", lvds1, model_scr(b2b[c-2], 8'h01));
            end
        end
        i_valid = 1'b0;
        repeat (2) tick();

        // Training on dut1 (3 cycles); dut0 starts its 64-cycle burst too.
        i_train = 1'b1;
        tick();
        i_train = 1'b0;
        chk("trn_n0_flag", 64'(trn1), 64'd0);
        chk("trn_n0_lvds", lvds1, 64'h8080808080808080);
        tick();
        chk("trn_n1_flag", 64'(trn1), 64'd1);
        chk("trn_n1_lvds", lvds1, 64'h808080807F7F7F7F);
        chk("trn_n1_d0",   lvds0, 64'h00000000FFFFFFFF);
        chk("trn_n1_done", 64'(done1), 64'd0);
        i_train = 1'b1;
        tick();
        i_train = 1'b0;
        chk("trn_n2_lvds", lvds1, 64'h808080807F7F7F7F);
        tick();
        chk("trn_n3_lvds", lvds1, 64'h808080807F7F7F7F);
        chk("trn_n3_flag", 64'(trn1), 64'd1);
        chk("trn_n3_done", 64'(done1), 64'd0);
        tick();
        chk("trn_n4_flag", 64'(trn1), 64'd0);
        chk("trn_n4_done", 64'(done1), 64'd1);
        chk("trn_n4_lvds", lvds1, 64'h8080808080808080);
        tick();
        chk("trn_n5_done", 64'(done1), 64'd0);
        chk("trn_n5_flag", 64'(trn1), 64'd0);

        // Backpressure on dut0 while it is still training: exactly 4 accepts.
        acc = 0;
        i_valid = 1'b1;
        i_data  = bp[0];
        for (int s = 0; s < 6; s++) begin
            chk("bp_ready", 64'(rdy0), 64'(acc < 4));
            took = rdy0;
            tick();
            if (took) acc++;
            i_data = bp[acc];
        end
        i_valid = 1'b0;
        chk("bp_accepts", 64'(acc), 64'd4);

        w = 0;
        while (!done0 && w < 100) begin
            tick();
            w++;
        end
        chk("bp_done_seen", 64'(done0), 64'd1);
        for (int d = 0; d < 4; d++) begin
            tick();
            chk("bp_drain", lvds0, model_scr(bp[d], 8'h00));
        end
        tick();
        chk("bp_after_idle", lvds0, 64'h0);

        // Reset during a training burst drops it.
        i_train = 1'b1;
        tick();
        i_train = 1'b0;
        tick();
        chk("mid_trn_flag", 64'(trn1), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", 64'(rdy1), 64'd0);
        rst = 1'b0;
        tick();
        chk("mid_rst_flag", 64'(trn1), 64'd0);
        chk("mid_rst_lvds", lvds1, 64'h8080808080808080);
        tick();
        chk("mid_rst_done", 64'(done1), 64'd0);

        // Underflow counter saturation and clear priority.
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("uf_clear", 64'(uf0), 64'd0);
        repeat (65534) tick();
        chk("uf_fffe", 64'(uf0), 64'hFFFE);
        tick();
        chk("uf_ffff", 64'(uf0), 64'hFFFF);
        repeat (3) tick();
        chk("uf_sat", 64'(uf0), 64'hFFFF);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("uf_clear_inc", 64'(uf0), 64'd0);
        tick();
        chk("uf_restart", 64'(uf0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serdes_scramble_tx.md
# serdes_scramble_tx

Transmit-side lane packer for the Sony IMX LVDS path, used in sensor-emulation and loopback builds. Accepts 8 lane bytes per beat over a valid/ready handshake and buffers them in a small FIFO. Each cycle it emits one 64-bit bit-interleaved word for an 8:1 OSERDES bank, with per-lane polarity inversion. When no data is available it emits an idle word, and on request it emits a bitslip training pattern. Its lane/bit mapping is the exact inverse of `serdes_descramble`, so descrambling the output with the same invert map returns the input.

## Interface
- `INVERT_MAP`, 8'h00: bit k set → lane k output is inverted.
- `IDLE_WORD`, 8'h00: per-lane byte sent when the FIFO is empty.
- `TRAIN_PATTERN`, 8'hF0: per-lane byte sent during training.
- `TRAIN_CYCLES`, 64: training length in cycles, ≥1.
- `FIFO_DEPTH`, 4: power of 2, ≥2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_data` in 64: lane k = `i_data[8k+7:8k]`.
- `i_valid` in 1: `i_data` is valid.
- `o_ready` out 1: `!fifo_full`; low while `rst` is high.
- `i_train` in 1: single-cycle training request.
- `i_clear` in 1: clears `o_underflow_count`.
- `o_lvds` out 64: registered OSERDES word.
- `o_training` out 1: high while in the TRAIN state.
- `o_train_done` out 1: one-cycle pulse.
- `o_underflow_count` out 16: saturating count of idle words inserted while in RUN.

## Operation
- Lane map: `o_lvds[8*(7-b)+(7-k)] = lane_k[b] ^ INVERT_MAP[k]`, for b,k in 0..7 and b=7 the lane MSB.
- Push: occurs when `i_valid && o_ready`. Pop: occurs when state = RUN and the FIFO is non-empty. A push and a pop in the same cycle leave the FIFO count unchanged.
- States:
  - RUN (the reset state): pop one beat per cycle and send it. If the FIFO is empty, send `IDLE_WORD` on every lane and increment `o_underflow_count`, saturating at 16'hFFFF.
  - TRAIN: entered the cycle after `i_train` is sampled in RUN.
    - Sends `TRAIN_PATTERN` on every lane for exactly `TRAIN_CYCLES` cycles.
    - No pops occur. Pushes still proceed until the FIFO is full.
    - Underflow is not counted.
    - Returns to RUN after the last training cycle; `o_train_done` pulses on the first RUN cycle.
- `i_train` while already in TRAIN: ignored, and the training counter is not restarted.
- `i_clear` and an increment in the same cycle: the count becomes 0.
- Reset mid-operation: the FIFO is flushed, state → RUN, the training counter is cleared, and any partially sent training sequence is dropped.
- Inversion applies to idle and training words as well as to data.

## Timing
- Reset values:
  - `o_lvds` = scrambled `IDLE_WORD` on all lanes, with inversion applied (not necessarily 0).
  - `o_ready`=0 while `rst` is high, and 1 in the first cycle after release.
  - `o_training`=0, `o_train_done`=0, `o_underflow_count`=0.
- Latency, with the FIFO empty in RUN: a beat pushed at edge N appears on `o_lvds` after edge N+2.
- Back-to-back pushes produce back-to-back output words with no bubbles.
- `i_train` sampled at edge N:
  - `o_training` rises and the first pattern word appears after edge N+1.
  - Pattern words occupy cycles N+1 … N+TRAIN_CYCLES.
  - `o_train_done` is high in cycle N+TRAIN_CYCLES+1, together with the first data or idle word.
- `o_ready` is a function of registered FIFO state only. It has no combinational path from `i_valid`.

## Structure
- Shared package `serdes_lvds_pkg` holds:
  - `LANES`=8 and `BITS`=8;
  - the state encoding (RUN, TRAIN);
  - a `lane_scramble` function implementing the lane map, reusable by the descramble side and by benches.
- One sub-module, `serdes_tx_fifo`: a synchronous FIFO with registered full/empty flags and a count output.
- Top level contains the FSM, the training counter, the underflow counter, and the output register.

## Test plan
- Reset release with defaults → `o_lvds`=64'h0, `o_ready`=1 at cycle 1, and `o_underflow_count` incrementing by 1 per cycle.
- Reset release with `INVERT_MAP`=8'h01 and FIFO idle → `o_lvds`=64'h8080808080808080.
- Push `i_data`=64'h0807060504030201 at edge N with the FIFO empty → `o_lvds`=64'hAA661E0100000000 after edge N+2. Feeding that word to `serdes_descramble` yields `o_lvds0`..`o_lvds7` = 1..8.
- Hold `i_valid` with no pops, by pulsing `i_train` beforehand → `o_ready` drops after exactly 4 accepts. After training ends, the 4 beats drain in push order on consecutive cycles.
- `i_train` at N with `TRAIN_CYCLES`=3 → `o_lvds`=scrambled 8'hF0 on every lane for cycles N+1..N+3, `o_train_done` high only at N+4. A second `i_train` at N+2 has no effect.
- Force `o_underflow_count` to 16'hFFFE and leave the FIFO empty → it reaches FFFF and holds. `i_clear` asserted together with an underflow → count = 0.
